lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
- Slave end of the 8-bit HD44780-style LCD write bus driven by the calculator (lcd_data, lcd_e, lcd_rs, lcd_rw).
- Decodes command and data transfers into a 2x16 character shadow memory and a cursor/mode state, and models the busy time after each instruction.
- Exposes a registered character readback port so that bench checkers and a mirror display can inspect screen contents.
- Lives on the same clock as the calculator; no input synchronisers.

Parameters:
- BUSY_CYCLES, 37: clk cycles busy after any accepted instruction except clear.
- CLEAR_CYCLES, 1520: clk cycles busy after clear display (0x01).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- lcd_data  in  8  bus data/command byte.
- lcd_e  in  1  enable; a transfer is latched on its falling edge.
- lcd_rs  in  1  0 = instruction, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- i_rd_idx  in  5  shadow cell index: 0-15 is line 1, 16-31 is line 2.
- o_char  out  8  contents of cell i_rd_idx, registered.
- o_status  out  8  {busy, addr[6:0]}, valid while lcd_rw=1 and lcd_rs=0.
- o_disp_on  out  1  display-on bit D from display control.
- o_wr_strobe  out  1  one-cycle pulse per accepted data write.
- o_err  out  1  one-cycle pulse per rejected transfer.

Behaviour:
- Reset (rst=0, async):
  - All 32 cells = 0x20.
  - addr = 0x00, inc = 1, o_disp_on = 0, busy counter = 0.
  - o_char = 0x20, o_wr_strobe = 0, o_err = 0.
- Edge detect: e_q registers lcd_e. Strobe = e_q & ~lcd_e (1-cycle latency to the fall).
- Strobe is evaluated using lcd_rs, lcd_rw and lcd_data sampled in the same cycle.
- Strobe with lcd_rw=1: no state change.
- Strobe with lcd_rw=0 and busy≠0: transfer dropped, o_err=1, busy counter not reloaded.
- Instruction decode (lcd_rs=0, lcd_rw=0, not busy), priority by MSB:
  - 1xxxxxxx set DDRAM address, a = data[6:0]:
    - a in 0x00-0x0F or 0x40-0x4F: addr = a.
    - Otherwise: o_err=1, addr unchanged.
  - 01xxxxxx CGRAM address: ignored, o_err=1.
  - 001xxxxx function set: accepted, no state change.
  - 0001xxxx cursor shift: accepted, no state change.
  - 00001Dxx display control: o_disp_on = D.
  - 000001Ix entry mode: inc = I.
  - 0000001x return home: addr = 0x00.
  - 00000001 clear: all cells = 0x20, addr = 0x00, inc = 1; busy = CLEAR_CYCLES.
  - 00000000: ignored, o_err=1, no busy.
  - Every other accepted instruction loads busy = BUSY_CYCLES.
- Data write (lcd_rs=1, lcd_rw=0, not busy):
  - cell[idx(addr)] = lcd_data; o_wr_strobe=1; busy = BUSY_CYCLES.
  - Address then steps by inc.
  - inc=1: 0x0F→0x40, 0x4F→0x00, else +1.
  - inc=0: 0x00→0x4F, 0x40→0x0F, else -1.
  - idx(addr) = addr[6] ? 16+addr[3:0] : addr[3:0].
- Busy counter:
  - Decrements by 1 per cycle while nonzero.
  - busy flag = (count≠0).
  - A strobe in the cycle the count reaches 0 is accepted.
- o_status: combinational {busy, addr}. Drives 0x00 when not (lcd_rw=1 and lcd_rs=0).
- o_char: registered, 1-cycle latency from i_rd_idx.
  - A read and a write to the same cell in the same cycle returns the old value.
  - After clear, reads return 0x20 from the cycle after the strobe.
- Reset asserted mid-clear or mid-busy: all state returns to reset values immediately.
- lcd_e held high indefinitely: nothing happens until it falls.
- Rising edge of lcd_e: no action.

Test Plan:
- Reset, then write data 0x31,0x32 (rs=1, E pulse ≥1 cycle, gap > BUSY_CYCLES) -> cells 0,1 = 0x31,0x32; addr=0x02; two o_wr_strobe pulses; cell 2 stays 0x20.
- Set addr 0x8F, write 0x41,0x42 -> cell 15 = 0x41, cell 16 = 0x42; o_status low bits = 0x41.
- Entry mode 0x04, set addr 0xC0, write 0x5A -> cell 16 = 0x5A; addr = 0x0F.
- Write 0x01, then read status after 10 cycles -> o_status[7]=1 and all cells 0x20. A data write at cycle 100 -> o_err=1, memory unchanged. At CLEAR_CYCLES+2, o_status = 0x00.
- Set addr 0x90 -> o_err pulse, addr unchanged. Write 0x0C -> o_disp_on=1. Write 0x48 -> o_err (CGRAM).
- Drive rst=0 mid-clear (cycle 500) -> busy=0, addr=0x00, o_disp_on=0 before the next clk edge.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// Slave end of an 8-bit HD44780-style LCD write bus. It keeps a 2x16 character
// shadow memory plus cursor, entry-mode and display-on state, models the busy
// time after each instruction, and offers a registered character readback port.
module lcd_bus_responder #(
    parameter int unsigned BUSY_CYCLES  = 37,
    parameter int unsigned CLEAR_CYCLES = 1520
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcd_data,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [4:0] i_rd_idx,
    output logic [7:0] o_char,
    output logic [7:0] o_status,
    output logic       o_disp_on,
    output logic       o_wr_strobe,
    output logic       o_err
);
    localparam int unsigned CntW  = 16;
    localparam logic [7:0]  Blank = 8'h20;

    logic            e_q;
    logic            strobe;
    logic            busy;
    logic [CntW-1:0] busy_q, busy_d;
    logic [6:0]      addr_q, addr_d, addr_step;
    logic            inc_q, inc_d;
    logic            disp_q, disp_d;
    logic            err_q, err_d;
    logic            wr_q, wr_d;
    logic            clear_all;
    logic            wr_en;
    logic [4:0]      wr_idx;
    logic [6:0]      set_a;
    logic            set_ok;
    logic [7:0]      mem_q [32];
    logic [7:0]      char_q;

    // Transfers are taken on the falling edge of E, one cycle after it happens.
    assign strobe = e_q & ~lcd_e;
    assign busy   = (busy_q != '0);

    // Line 1 lives at 0x00-0x0F, line 2 at 0x40-0x4F; fold both into 0..31.
    assign wr_idx = {addr_q[6], addr_q[3:0]};
    assign set_a  = lcd_data[6:0];
    assign set_ok = (set_a <= 7'h0F) || ((set_a >= 7'h40) && (set_a <= 7'h4F));

    // Cursor step after a data write, wrapping between the two lines.
    always_comb begin
        addr_step = addr_q;
        if (inc_q) begin
            case (addr_q)
                7'h0F:   addr_step = 7'h40;
                7'h4F:   addr_step = 7'h00;
                default: addr_step = addr_q + 7'd1;
            endcase
        end else begin
            case (addr_q)
                7'h00:   addr_step = 7'h4F;
                7'h40:   addr_step = 7'h0F;
                default: addr_step = addr_q - 7'd1;
            endcase
        end
    end

    // Transfer decode and next-state for cursor, mode, busy and pulse outputs.
    always_comb begin
        addr_d    = addr_q;
        inc_d     = inc_q;
        disp_d    = disp_q;
        busy_d    = busy ? busy_q - CntW'(1) : busy_q;
        err_d     = 1'b0;
        wr_d      = 1'b0;
        clear_all = 1'b0;
        wr_en     = 1'b0;
        if (strobe && !lcd_rw) begin
            if (busy) begin
                // Dropped; the running busy count is left alone.
                err_d = 1'b1;
            end else if (lcd_rs) begin
                wr_en  = 1'b1;
                wr_d   = 1'b1;
                busy_d = CntW'(BUSY_CYCLES);
                addr_d = addr_step;
            end else begin
                casez (lcd_data)
                    8'b1???????: begin
                        if (set_ok) begin
                            addr_d = set_a;
                            busy_d = CntW'(BUSY_CYCLES);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    8'b01??????: err_d = 1'b1;
                    8'b001?????: busy_d = CntW'(BUSY_CYCLES);
                    8'b0001????: busy_d = CntW'(BUSY_CYCLES);
                    8'b00001???: begin
                        disp_d = lcd_data[2];
                        busy_d = CntW'(BUSY_CYCLES);
                    end
                    8'b000001??: begin
                        inc_d  = lcd_data[1];
                        busy_d = CntW'(BUSY_CYCLES);
                    end
                    8'b0000001?: begin
                        addr_d = 7'h00;
                        busy_d = CntW'(BUSY_CYCLES);
                    end
                    8'b00000001: begin
                        clear_all = 1'b1;
                        addr_d    = 7'h00;
                        inc_d     = 1'b1;
                        busy_d    = CntW'(CLEAR_CYCLES);
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q    <= 1'b0;
            busy_q <= '0;
            addr_q <= 7'h00;
            inc_q  <= 1'b1;
            disp_q <= 1'b0;
            err_q  <= 1'b0;
            wr_q   <= 1'b0;
        end else begin
            e_q    <= lcd_e;
            busy_q <= busy_d;
            addr_q <= addr_d;
            inc_q  <= inc_d;
            disp_q <= disp_d;
            err_q  <= err_d;
            wr_q   <= wr_d;
        end
    end

    // Shadow character memory; clear and reset fill it with spaces.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mem_q[i] <= Blank;
        end else if (clear_all) begin
            for (int i = 0; i < 32; i++) mem_q[i] <= Blank;
        end else if (wr_en) begin
            mem_q[wr_idx] <= lcd_data;
        end
    end

    // Registered readback; a same-cycle write to the same cell returns old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            char_q <= Blank;
        end else begin
            char_q <= mem_q[i_rd_idx];
        end
    end

    assign o_char      = char_q;
    assign o_disp_on   = disp_q;
    assign o_wr_strobe = wr_q;
    assign o_err       = err_q;
    assign o_status    = (lcd_rw && !lcd_rs) ? {busy, addr_q} : 8'h00;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: data writes, line wrap, entry mode,
// clear/busy timing, error cases, E held high and asynchronous reset.
module tb_lcd_bus_responder;
    logic       clk;
    logic       rst;
    logic [7:0] lcd_data;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [4:0] i_rd_idx;
    logic [7:0] o_char;
    logic [7:0] o_status;
    logic       o_disp_on;
    logic       o_wr_strobe;
    logic       o_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int err_cnt = 0;

    lcd_bus_responder #(
        .BUSY_CYCLES (37),
        .CLEAR_CYCLES(1520)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_data   (lcd_data),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .i_rd_idx   (i_rd_idx),
        .o_char     (o_char),
        .o_status   (o_status),
        .o_disp_on  (o_disp_on),
        .o_wr_strobe(o_wr_strobe),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_wr_strobe) wr_cnt <= wr_cnt + 1;
        if (o_err) err_cnt <= err_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    // One E pulse; returns the pulse outputs seen right after the accepting edge.
    task automatic bus_xfer(input logic rs, input logic [7:0] d,
                            output logic err, output logic wr);
        lcd_rs   = rs;
        lcd_rw   = 1'b0;
        lcd_data = d;
        lcd_e    = 1'b1;
        tick();
        lcd_e = 1'b0;
        tick();
        err = o_err;
        wr  = o_wr_strobe;
    endtask

    task automatic get_status(output logic [7:0] s);
        lcd_rw = 1'b1;
        lcd_rs = 1'b0;
        #1;
        s      = o_status;
        lcd_rw = 1'b0;
    endtask

    task automatic read_cell(input logic [4:0] idx, output logic [7:0] v);
        i_rd_idx = idx;
        tick();
        v = o_char;
    endtask

    task automatic test_reset();
        logic [7:0] s;
        rst = 1'b0;
        wait_ticks(3);
        get_status(s);
        checks++;
        if (s !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", s); end
        checks++;
        if (o_char !== 8'h20) begin errors++; $display("FAIL reset_char: got %h want 20", o_char); end
        checks++;
        if ({o_disp_on, o_wr_strobe, o_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {o_disp_on, o_wr_strobe, o_err});
        end
        rst = 1'b1;
        wait_ticks(2);
    endtask

    task automatic test_data_write();
        logic e, w;
        logic [7:0] v, s;
        int w0;
        w0 = wr_cnt;
        bus_xfer(1'b1, 8'h31, e, w);
        checks++;
        if ({e, w} !== 2'b01) begin errors++; $display("FAIL dw_pulse: got %b want 01", {e, w}); end
        tick();
        checks++;
        if (o_wr_strobe !== 1'b0) begin errors++; $display("FAIL dw_one_cycle: got %b want 0", o_wr_strobe); end
        wait_ticks(40);
        bus_xfer(1'b1, 8'h32, e, w);
        wait_ticks(40);
        checks++;
        if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL dw_count: got %0d want 2", wr_cnt - w0); end
        read_cell(5'd0, v);
        checks++;
        if (v !== 8'h31) begin errors++; $display("FAIL dw_cell0: got %h want 31", v); end
        read_cell(5'd1, v);
        checks++;
        if (v !== 8'h32) begin errors++; $display("FAIL dw_cell1: got %h want 32", v); end
        read_cell(5'd2, v);
        checks++;
        if (v !== 8'h20) begin errors++; $display("FAIL dw_cell2: got %h want 20", v); end
        get_status(s);
        checks++;
        if (s !== 8'h02) begin errors++; $display("FAIL dw_addr: got %h want 02", s); end
    endtask

    task automatic test_wrap();
        logic e, w;
        logic [7:0] v, s;
        bus_xfer(1'b0, 8'h8F, e, w);
        wait_ticks(40);
        bus_xfer(1'b1, 8'h41, e, w);
        wait_ticks(40);
        bus_xfer(1'b1, 8'h42, e, w);
        wait_ticks(40);
        read_cell(5'd15, v);
        checks++;
        if (v !== 8'h41) begin errors++; $display("FAIL wrap_cell15: got %h want 41", v); end
        read_cell(5'd16, v);
        checks++;
        if (v !== 8'h42) begin errors++; $display("FAIL wrap_cell16: got %h want 42", v); end
        get_status(s);
        checks++;
        if (s !== 8'h41) begin errors++; $display("FAIL wrap_addr: got %h want 41", s); end
        // Status bus is idle unless this is an instruction read.
        lcd_rw = 1'b0;
        lcd_rs = 1'b0;
        #1;
        checks++;
        if (o_status !== 8'h00) begin errors++; $display("FAIL status_idle: got %h want 00", o_status); end
    endtask

    task automatic test_entry_dec();
        logic e, w;
        logic [7:0] v, s;
        bus_xfer(1'b0, 8'h04, e, w);
        wait_ticks(40);
        bus_xfer(1'b0, 8'hC0, e, w);
        wait_ticks(40);
        bus_xfer(1'b1, 8'h5A, e, w);
        wait_ticks(40);
        read_cell(5'd16, v);
        checks++;
        if (v !== 8'h5A) begin errors++; $display("FAIL dec_cell16: got %h want 5a", v); end
        get_status(s);
        checks++;
        if (s !== 8'h0F) begin errors++; $display("FAIL dec_addr: got %h want 0f", s); end
        bus_xfer(1'b0, 8'h06, e, w);
        wait_ticks(40);
    endtask

    task automatic test_errors();
        logic e, w;
        logic [7:0] s;
        bus_xfer(1'b0, 8'h90, e, w);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL bad_addr_err: got %b want 1", e); end
        wait_ticks(2);
        get_status(s);
        checks++;
        if (s !== 8'h0F) begin errors++; $display("FAIL bad_addr_keep: got %h want 0f", s); end
        bus_xfer(1'b0, 8'h0C, e, w);
        wait_ticks(40);
        checks++;
        if (o_disp_on !== 1'b1) begin errors++; $display("FAIL disp_on: got %b want 1", o_disp_on); end
        bus_xfer(1'b0, 8'h48, e, w);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL cgram_err: got %b want 1", e); end
        wait_ticks(2);
        bus_xfer(1'b0, 8'h00, e, w);
        get_status(s);
        checks++;
        if ({e, s} !== {1'b1, 8'h0F}) begin
            errors++; $display("FAIL null_cmd: got err=%b st=%h want err=1 st=0f", e, s);
        end
        wait_ticks(2);
    endtask

    task automatic test_clear();
        logic e, w;
        logic [7:0] v, s;
        int acc;
        int bad;
        bus_xfer(1'b0, 8'h01, e, w);
        acc = cyc;
        wait_ticks(10);
        get_status(s);
        checks++;
        if (s[7] !== 1'b1) begin errors++; $display("FAIL clear_busy: got %b want 1", s[7]); end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            read_cell(5'(i), v);
            if (v !== 8'h20) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL clear_cells: got %0d non-blank want 0", bad); end
        wait_until(acc + 100);
        bus_xfer(1'b1, 8'h77, e, w);
        checks++;
        if ({e, w} !== 2'b10) begin errors++; $display("FAIL busy_drop: got %b want 10", {e, w}); end
        read_cell(5'd0, v);
        checks++;
        if (v !== 8'h20) begin errors++; $display("FAIL busy_nowrite: got %h want 20", v); end
        wait_until(acc + 1519);
        get_status(s);
        checks++;
        if (s !== 8'h80) begin errors++; $display("FAIL clear_last_busy: got %h want 80", s); end
        wait_until(acc + 1522);
        get_status(s);
        checks++;
        if (s !== 8'h00) begin errors++; $display("FAIL clear_done: got %h want 00", s); end
    endtask

    task automatic test_back_to_back();
        logic e, w;
        logic [7:0] v;
        int a, b;
        i_rd_idx = 5'd0;
        bus_xfer(1'b1, 8'h41, e, w);
        a = cyc;
        checks++;
        if (o_char !== 8'h20) begin errors++; $display("FAIL rw_same_old: got %h want 20", o_char); end
        tick();
        checks++;
        if (o_char !== 8'h41) begin errors++; $display("FAIL rw_same_new: got %h want 41", o_char); end
        // Strobe lands one cycle before the count reaches zero.
        wait_until(a + 35);
        bus_xfer(1'b1, 8'h42, e, w);
        checks++;
        if ({e, w} !== 2'b10) begin errors++; $display("FAIL busy_edge_drop: got %b want 10", {e, w}); end
        bus_xfer(1'b1, 8'h43, e, w);
        b = cyc;
        checks++;
        if ({e, w} !== 2'b01) begin errors++; $display("FAIL no_reload: got %b want 01", {e, w}); end
        // Strobe lands exactly in the cycle the count is zero.
        wait_until(b + 36);
        bus_xfer(1'b1, 8'h44, e, w);
        checks++;
        if ({e, w} !== 2'b01) begin errors++; $display("FAIL busy_edge_accept: got %b want 01", {e, w}); end
        read_cell(5'd1, v);
        checks++;
        if (v !== 8'h43) begin errors++; $display("FAIL b2b_cell1: got %h want 43", v); end
        read_cell(5'd2, v);
        checks++;
        if (v !== 8'h44) begin errors++; $display("FAIL b2b_cell2: got %h want 44", v); end
        wait_ticks(40);
    endtask

    task automatic test_e_held();
        logic [7:0] v;
        int w0;
        w0 = wr_cnt;
        lcd_rs   = 1'b1;
        lcd_rw   = 1'b0;
        lcd_data = 8'h55;
        lcd_e    = 1'b1;
        wait_ticks(20);
        read_cell(5'd3, v);
        checks++;
        if ({v, 8'(wr_cnt - w0)} !== {8'h20, 8'd0}) begin
            errors++; $display("FAIL e_high_idle: got cell=%h wr=%0d want 20/0", v, wr_cnt - w0);
        end
        lcd_e = 1'b0;
        wait_ticks(2);
        read_cell(5'd3, v);
        checks++;
        if ({v, 8'(wr_cnt - w0)} !== {8'h55, 8'd1}) begin
            errors++; $display("FAIL e_fall_write: got cell=%h wr=%0d want 55/1", v, wr_cnt - w0);
        end
        wait_ticks(40);
    endtask

    task automatic test_reset_mid_clear();
        logic e, w;
        logic [7:0] s;
        int acc;
        bus_xfer(1'b0, 8'h01, e, w);
        acc = cyc;
        wait_until(acc + 500);
        get_status(s);
        checks++;
        if ({s, o_disp_on} !== {8'h80, 1'b1}) begin
            errors++; $display("FAIL pre_reset: got st=%h d=%b want 80/1", s, o_disp_on);
        end
        rst = 1'b0;
        lcd_rw = 1'b1;
        lcd_rs = 1'b0;
        #2;
        checks++;
        if ({o_status, o_disp_on} !== {8'h00, 1'b0}) begin
            errors++; $display("FAIL async_reset: got st=%h d=%b want 00/0", o_status, o_disp_on);
        end
        lcd_rw = 1'b0;
        wait_ticks(2);
        rst = 1'b1;
        wait_ticks(2);
    endtask

    initial begin
        rst      = 1'b0;
        lcd_data = 8'h00;
        lcd_e    = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        i_rd_idx = 5'd0;
        test_reset();
        test_data_write();
        test_wrap();
        test_entry_dec();
        test_errors();
        test_clear();
        test_back_to_back();
        test_e_held();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
